// File: rtl/gpio_event_capture_pkg.sv
// rtl/gpio_event_capture_pkg.sv - shared event type and default sizing for GPIO event capture
package gpio_event_capture_pkg;

   localparam int unsigned DEF_NUM_GPIO   = 32;
   localparam int unsigned DEF_FIFO_DEPTH = 8;
   localparam int unsigned DEF_TS_WIDTH   = 16;

   // Layout of one queued event at the default sizing; the top packs {value, ts} in this order.
   typedef struct packed {
      logic [DEF_NUM_GPIO-1:0] value;
      logic [DEF_TS_WIDTH-1:0] ts;
   } event_t;

endpackage

// File: rtl/gpio_event_fifo.sv
// rtl/gpio_event_fifo.sv - first-word fall-through event FIFO with occupancy count
module gpio_event_fifo
   import gpio_event_capture_pkg::*;
#(
   parameter int unsigned WIDTH = $bits(event_t),
   parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wr_valid_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_ready_i,
   output logic                       rd_valid_o,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             empty;
   logic             rd_en;
   logic             wr_en;

   assign empty  = (wr_ptr == rd_ptr);
   assign full_o = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en  = rd_ready_i && !empty;
   // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
   assign wr_en  = wr_valid_i && (!full_o || rd_en);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data_i;
   end

   // Head is forced to zero when empty so outputs read as zero out of reset.
   assign rd_valid_o = !empty;
   assign rd_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign count_o    = CNT_W'(wr_ptr - rd_ptr);

endmodule

// File: rtl/gpio_event_capture.sv
// rtl/gpio_event_capture.sv - synchronizes MCU pins and queues timestamped change events
module gpio_event_capture
   import gpio_event_capture_pkg::*;
#(
   parameter int unsigned NUM_GPIO   = DEF_NUM_GPIO,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned TS_WIDTH   = DEF_TS_WIDTH
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NUM_GPIO-1:0]             gpio_i,
   input  logic                            en_i,
   input  logic [NUM_GPIO-1:0]             mask_i,
   output logic                            evt_valid_o,
   input  logic                            evt_ready_i,
   output logic [NUM_GPIO-1:0]             evt_value_o,
   output logic [TS_WIDTH-1:0]             evt_ts_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] evt_count_o,
   output logic                            overflow_o,
   input  logic                            overflow_clr_i
);

   localparam int unsigned EVT_W = NUM_GPIO + TS_WIDTH;

   logic [NUM_GPIO-1:0] sync1;
   logic [NUM_GPIO-1:0] sync2;
   logic [NUM_GPIO-1:0] prev;
   logic [NUM_GPIO-1:0] change;
   logic [TS_WIDTH-1:0] ts;
   logic [EVT_W-1:0]    head;
   logic                push;
   logic                pop;
   logic                full;
   logic                drop;

   // prev follows sync2 even while disabled, so changes seen while off are never replayed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
         ts    <= '0;
      end else begin
         sync1 <= gpio_i;
         sync2 <= sync1;
         prev  <= sync2;
         if (en_i) ts <= ts + TS_WIDTH'(1);
      end
   end

   assign change = (sync2 ^ prev) & mask_i;
   assign push   = en_i && (|change);
   assign pop    = evt_valid_o && evt_ready_i;
   assign drop   = push && full && !pop;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             overflow_o <= 1'b0;
      else if (drop)           overflow_o <= 1'b1;
      else if (overflow_clr_i) overflow_o <= 1'b0;
   end

   gpio_event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wr_valid_i (push),
      .wr_data_i  ({sync2, ts}),
      .rd_ready_i (evt_ready_i),
      .rd_valid_o (evt_valid_o),
      .rd_data_o  (head),
      .full_o     (full),
      .count_o    (evt_count_o)
   );

   assign {evt_value_o, evt_ts_o} = head;

endmodule

// File: doc/gpio_event_capture.md
# gpio_event_capture

Captures pin activity driven by the MCU and delivers it to the processing system (PS) on the FPGA. The mini-MCU GPIO/peripheral pads are already driven from the PS GPIO_O bank; this block covers the opposite direction.
- Synchronizes a bank of MCU-side pin levels and detects changes on unmasked pins.
- Records each change as a timestamped snapshot in a FIFO that PS logic drains over a valid/ready handshake.
- Sits in the FPGA top level, between the pad nets and the PS GPIO_I / PL fabric.

## Interface
Parameters:
- NUM_GPIO, 32, number of monitored pins
- FIFO_DEPTH, 8, event FIFO entries (power of two, ≥2)
- TS_WIDTH, 16, timestamp counter width

Ports:
- clk_i  in  1  block clock; single clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- gpio_i  in  NUM_GPIO  raw pin levels, asynchronous to clk_i
- en_i  in  1  capture enable; also gates timestamp counting
- mask_i  in  NUM_GPIO  1 = pin participates in change detection (quasi-static)
- evt_valid_o  out  1  FIFO head valid
- evt_ready_i  in  1  consumer accepts head
- evt_value_o  out  NUM_GPIO  snapshot of synchronized pins at event
- evt_ts_o  out  TS_WIDTH  timestamp of event
- evt_count_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
- overflow_o  out  1  sticky: an event was dropped
- overflow_clr_i  in  1  clears overflow_o

## Operation
- Synchronizer: 2-flop per pin (sync1 → sync2), both reset to 0.
- prev register: loads sync2 every cycle, regardless of en_i; reset 0.
- change = (sync2 ^ prev) & mask_i; push = en_i && (change != 0).
- Event word = {sync2, ts}. ts is the counter value in the push cycle.
- Timestamp counter: reset 0; increments by 1 each cycle while en_i; wraps 2^TS_WIDTH−1 → 0 silently.
- FIFO is first-word fall-through:
  - evt_valid_o = !empty.
  - Pop on evt_valid_o && evt_ready_i.
  - evt_value_o/evt_ts_o stay stable while valid && !ready.
  - evt_ready_i while empty is ignored.
- Full FIFO, push without pop: event dropped, overflow_o set.
- Full FIFO, push with pop: both occur; no overflow; count unchanged.
- Empty FIFO, push with pop: pop is impossible (valid=0); count becomes 1.
- overflow_clr_i and an overflow in the same cycle: set wins, overflow_o stays 1.
- Multiple pins changing in one cycle produce one event.
- Changes while en_i=0 are lost: prev still tracks sync2, so re-enabling does not replay them.
- Pins held high through reset release with mask set: produce exactly one event (prev resets 0).

## Timing
- Reset values: evt_valid_o=0, evt_value_o=0, evt_ts_o=0, evt_count_o=0, overflow_o=0.
- gpio_i settles before edge k:
  - sync2 updated at edge k+1.
  - Push written at edge k+2.
  - evt_valid_o high after edge k+2.
  - Total latency: 3 edges.
- Pin toggles shorter than one clock may be missed.
- Reset assertion mid-operation: all state (FIFO contents, pointers, ts, overflow) clears immediately, without waiting for a clock edge.
- Reset deassertion: synchronized to clk_i externally.
- evt_count_o and overflow_o are registered and update at the edge that performs the push/pop.

## Structure
- Package gpio_event_capture_pkg holds:
  - event_t packed struct {value[NUM_GPIO], ts[TS_WIDTH]}
  - default parameter constants
- Sub-module gpio_event_fifo:
  - FWFT FIFO of event_t, FIFO_DEPTH entries.
  - Wrap-around read/write pointers with an extra MSB for full/empty.
  - Exposes count.
- Top level contains: synchronizer, prev/change logic, timestamp counter, overflow flag.

## Test plan
- Reset, en_i=1, mask=all-ones, gpio_i=0, then gpio_i[3] 0→1 before edge 10 → evt_valid_o after edge 12, evt_value_o=0x0000_0008, evt_ts_o equals counter value in push cycle.
- mask_i=0xFFFF_FFF7, toggle gpio_i[3] only → no event. Toggle gpio_i[0] and gpio_i[5] in the same cycle → one event, value=0x21 (with gpio_i[3] level included).
- Hold evt_ready_i=0 and generate 9 events (depth 8):
  - evt_count_o=8, overflow_o=1.
  - Drained order is events 1..8; event 9 is absent.
  - Pulse overflow_clr_i → overflow_o=0.
- FIFO full, push and evt_ready_i in the same cycle → overflow_o stays 0, count stays 8, new event is last out.
- TS_WIDTH=4, en_i=1 for 20 cycles between two events → timestamps differ by 20 mod 16 = 4.
- Assert rst_ni mid-stream with 5 events queued → outputs go to reset values with no clock edge. After release, the first event drained is the new post-reset event.
